disp_scan_sched: RTL and testbench

//  Scan scheduler for the 4-digit multiplexed 7-segment display.
//  - Time-shares the single segment bus L between four digit patterns L1..L4.
//  - Inserts a blanking interval before each digit to remove ghosting.
//  - Honours a per-digit enable mask and emits a frame-done strobe.
//  - Advanced by an external tick (e.g. the kHz enable from the seconds prescaler).

---
 rtl/disp_scan_sched.sv | 164 ++++++++++++++++
 tb/tb_disp_scan_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : disp_scan_sched                                            |
// | Description : Scan scheduler for a 4-digit multiplexed 7-segment display.|
// |               Time-shares the segment bus between four digit patterns,   |
// |               blanks all anodes before each digit to suppress ghosting,  |
// |               honours a per-digit enable mask and strobes FRAME_DONE     |
// |               once per full scan. Advanced only on TICK_EN cycles.       |
// | Optional    : SCAN_BRIGHT_EN adds the BRIGHT port and a free-running     |
// |               3-bit PWM that gates the anode during DRIVE.               |
// | Ports       : CLK        in   system clock                               |
// |               RESET      in   synchronous active-high reset              |
// |               TICK_EN    in   scan advance enable (1-cycle pulse)        |
// |               L1..L4     in   segment patterns digits 0..3, active-low   |
// |               DIG_MASK   in   bit i = 1 enables digit i                  |
// |               BRIGHT     in   brightness 0..7 (SCAN_BRIGHT_EN only)      |
// |               SA         out  anode select, active-low, <=1 bit low      |
// |               L          out  segment bus, active-low                    |
// |               FRAME_DONE out  pulse at end of digit 3 drive phase        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module disp_scan_sched #(
  parameter int BLANK_TICKS = 1,  // 1..15
  parameter int DRIVE_TICKS = 3   // 1..15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK_EN,
  input  logic [7:0] L1,
  input  logic [7:0] L2,
  input  logic [7:0] L3,
  input  logic [7:0] L4,
  input  logic [3:0] DIG_MASK,
`ifdef SCAN_BRIGHT_EN
  input  logic [2:0] BRIGHT,
`endif
  output logic [3:0] SA,
  output logic [7:0] L,
  output logic       FRAME_DONE
);

  localparam logic [3:0] C_BLANK_LAST = 4'(BLANK_TICKS - 1);
  localparam logic [3:0] C_DRIVE_LAST = 4'(DRIVE_TICKS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [7:0] pat_q, pat_d;         // pattern captured at BLANK->DRIVE
  logic       en_q, en_d;           // mask bit captured at BLANK->DRIVE
  logic [3:0] sa_q, sa_d;
  logic [7:0] l_q, l_d;
  logic       frame_done_q, frame_done_d;
  logic [7:0] w_sel_pat;
  logic       w_pwm_on;

`ifdef SCAN_BRIGHT_EN
  logic [2:0] pwm_cnt_q, pwm_cnt_d;

  // Compare against the next count so the registered SA reflects the PWM
  // phase of the cycle in which it is actually visible.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 3'd1;
    w_pwm_on  = (pwm_cnt_d <= BRIGHT);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pwm_cnt_q <= 3'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  assign w_pwm_on = 1'b1;
`endif

  always_comb begin
    case (idx_q)
      2'd0:    w_sel_pat = L1;
      2'd1:    w_sel_pat = L2;
      2'd2:    w_sel_pat = L3;
      default: w_sel_pat = L4;
    endcase
  end

  // Next-state and next-output logic. Outputs are computed from the next
  // state so the registered SA/L change exactly one clock after the tick.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tick_cnt_d   = tick_cnt_q;
    pat_d        = pat_q;
    en_d         = en_q;
    frame_done_d = 1'b0;
    sa_d         = 4'hf;
    l_d          = 8'hff;

    if (TICK_EN) begin
      case (state_q)
        ST_BLANK: begin
          if (tick_cnt_q == C_BLANK_LAST) begin
            state_d    = ST_DRIVE;
            tick_cnt_d = 4'd0;
            pat_d      = w_sel_pat;
            en_d       = DIG_MASK[idx_q];
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        default: begin
          if (tick_cnt_q == C_DRIVE_LAST) begin
            state_d      = ST_BLANK;
            tick_cnt_d   = 4'd0;
            idx_d        = idx_q + 2'd1;
            frame_done_d = (idx_q == 2'd3);
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      endcase
    end

    // A masked digit still occupies its slot; only the anode stays off.
    if (state_d == ST_DRIVE) begin
      l_d = pat_d;
      if (en_d && w_pwm_on) begin
        sa_d = ~(4'b0001 << idx_d);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_BLANK;
      idx_q        <= 2'd0;
      tick_cnt_q   <= 4'd0;
      pat_q        <= 8'hff;
      en_q         <= 1'b0;
      sa_q         <= 4'hf;
      l_q          <= 8'hff;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tick_cnt_q   <= tick_cnt_d;
      pat_q        <= pat_d;
      en_q         <= en_d;
      sa_q         <= sa_d;
      l_q          <= l_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign SA         = sa_q;
  assign L          = l_q;
  assign FRAME_DONE = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_disp_scan_sched                                         |
// | Description : Directed self-checking bench for disp_scan_sched with      |
// |               default timing (1 blank tick, 3 drive ticks per digit).    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_disp_scan_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_en;
  logic [7:0] l1, l2, l3, l4;
  logic [3:0] dig_mask;
`ifdef SCAN_BRIGHT_EN
  logic [2:0] bright;
`endif
  logic [3:0] sa;
  logic [7:0] l;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  logic [3:0] e_sa;
  logic [7:0] e_l;
  logic       e_fd;

  always #5 clk = ~clk;

  disp_scan_sched #(
    .BLANK_TICKS(1),
    .DRIVE_TICKS(3)
  ) dut (
    .CLK       (clk),
    .RESET     (rst),
    .TICK_EN   (tick_en),
    .L1        (l1),
    .L2        (l2),
    .L3        (l3),
    .L4        (l4),
    .DIG_MASK  (dig_mask),
`ifdef SCAN_BRIGHT_EN
    .BRIGHT    (bright),
`endif
    .SA        (sa),
    .L         (l),
    .FRAME_DONE(frame_done)
  );

  // Expected outputs after the m-th tick since reset release: each digit
  // slot is 4 ticks (drive on ticks 0..2 of the slot, blank on tick 3).
  task automatic model(input int m, input logic [3:0] mask,
                       input logic [7:0] p0, input logic [7:0] p1,
                       input logic [7:0] p2, input logic [7:0] p3,
                       output logic [3:0] o_sa, output logic [7:0] o_l,
                       output logic o_fd);
    int d;
    int ph;
    logic [7:0] p;
    logic [3:0] onehot;
    d  = ((m - 1) / 4) % 4;
    ph = (m - 1) % 4;
    case (d)
      0:       p = p0;
      1:       p = p1;
      2:       p = p2;
      default: p = p3;
    endcase
    onehot = 4'b0001 << d;
    if (ph < 3) begin
      o_sa = mask[d] ? ~onehot : 4'hf;
      o_l  = p;
      o_fd = 1'b0;
    end else begin
      o_sa = 4'hf;
      o_l  = 8'hff;
      o_fd = (d == 3);
    end
  endtask

  task automatic check(input string tag, input logic [3:0] x_sa,
                       input logic [7:0] x_l, input logic x_fd);
    total++;
    assert (sa === x_sa) else begin
      bad++;
      $error("FAIL %s SA observed=%h expected=%h", tag, sa, x_sa);
    end
    total++;
    assert (l === x_l) else begin
      bad++;
      $error("FAIL %s L observed=%h expected=%h", tag, l, x_l);
    end
    total++;
    assert (frame_done === x_fd) else begin
      bad++;
      $error("FAIL %s FRAME_DONE observed=%b expected=%b", tag, frame_done, x_fd);
    end
    total++;
    assert ($countones(~sa) <= 1) else begin
      bad++;
      $error("FAIL %s SA_onehot observed=%h expected=at_most_one_low", tag, sa);
    end
  endtask

  task automatic do_reset(input string tag);
    rst     = 1'b1;
    tick_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check(tag, 4'hf, 8'hff, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    tick_en  = 1'b1;
    l1       = 8'h01;
    l2       = 8'h02;
    l3       = 8'h03;
    l4       = 8'h04;
    dig_mask = 4'hf;
`ifdef SCAN_BRIGHT_EN
    bright   = 3'd7;
`endif

    // 1: tick every cycle, all digits on, two full frames
    do_reset("t1_reset");
    for (int n = 1; n <= 32; n++) begin
      tick_en = 1'b1;
      @(negedge clk);
      model(n, 4'hf, 8'h01, 8'h02, 8'h03, 8'h04, e_sa, e_l, e_fd);
      check($sformatf("t1_n%0d", n), e_sa, e_l, e_fd);
    end

    // 2: tick every 4th cycle, outputs hold between ticks
    do_reset("t2_reset");
    for (int n = 1; n <= 64; n++) begin
      tick_en = ((n - 1) % 4 == 0);
      @(negedge clk);
      model((n - 1) / 4 + 1, 4'hf, 8'h01, 8'h02, 8'h03, 8'h04, e_sa, e_l, e_fd);
      if ((n - 1) % 4 != 0) e_fd = 1'b0;
      check($sformatf("t2_n%0d", n), e_sa, e_l, e_fd);
    end

    // 3: digits 0 and 2 masked, frame timing unchanged
    dig_mask = 4'b1010;
    do_reset("t3_reset");
    for (int n = 1; n <= 32; n++) begin
      tick_en = 1'b1;
      @(negedge clk);
      model(n, 4'b1010, 8'h01, 8'h02, 8'h03, 8'h04, e_sa, e_l, e_fd);
      check($sformatf("t3_n%0d", n), e_sa, e_l, e_fd);
    end
    dig_mask = 4'hf;

    // 4: L2 changes mid-drive of digit 1; visible only in next frame
    do_reset("t4_reset");
    for (int n = 1; n <= 24; n++) begin
      tick_en = 1'b1;
      if (n == 6) l2 = 8'h55;
      @(negedge clk);
      model(n, 4'hf, 8'h01, (n >= 17) ? 8'h55 : 8'h02, 8'h03, 8'h04,
            e_sa, e_l, e_fd);
      check($sformatf("t4_n%0d", n), e_sa, e_l, e_fd);
    end
    l2 = 8'h02;

    // 5: reset pulse during digit 2 drive, restart from digit 0
    do_reset("t5_reset");
    for (int n = 1; n <= 10; n++) begin
      tick_en = 1'b1;
      @(negedge clk);
      model(n, 4'hf, 8'h01, 8'h02, 8'h03, 8'h04, e_sa, e_l, e_fd);
      check($sformatf("t5_pre_n%0d", n), e_sa, e_l, e_fd);
    end
    rst = 1'b1;
    @(negedge clk);
    check("t5_midreset", 4'hf, 8'hff, 1'b0);
    rst = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick_en = 1'b1;
      @(negedge clk);
      model(n, 4'hf, 8'h01, 8'h02, 8'h03, 8'h04, e_sa, e_l, e_fd);
      check($sformatf("t5_post_n%0d", n), e_sa, e_l, e_fd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
